// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM.
// Sequences fetch, decode, execute, memory and writeback for a subset of RV32I.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD,
    MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  state_t st, nxt;
  logic   ill_q;
  logic   req_c, we_c, irw_c, pcw_c, rw_c, ret_c;
  logic   taken;

  // State register; reset forces FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= FETCH;
    else        st <= nxt;
  end

  // Sticky trap flag, set on entry to TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ill_q <= 1'b0;
    else if (nxt == TRAP) ill_q <= 1'b1;
  end

  // Branch condition from func3 and ALU flags.
  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = alu_lsb;
      3'b101, 3'b111: taken = !alu_lsb;
      default:        taken = 1'b0;
    endcase
  end

  // Next-state and per-state control outputs.
  always_comb begin
    nxt       = st;
    req_c     = 1'b0;
    we_c      = 1'b0;
    i_or_d    = 1'b0;
    irw_c     = 1'b0;
    pcw_c     = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    rw_c      = 1'b0;
    wb_sel    = 2'b00;
    ret_c     = 1'b0;
    unique case (st)
      FETCH: begin
        req_c     = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw_c = 1'b1;
          pcw_c = 1'b1;
          nxt   = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
        unique case (1'b1)
          opcode == OP_R:  nxt = EXEC_R;
          opcode == OP_I:  nxt = EXEC_I;
          opcode == OP_LD,
          opcode == OP_ST: nxt = ADDR;
          opcode == OP_BR: nxt = BRANCH;
          opcode == OP_J:  nxt = JAL;
          default:         nxt = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
        nxt       = WB_ALU;
      end
      WB_ALU: begin
        rw_c  = 1'b1;
        ret_c = 1'b1;
        nxt   = FETCH;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_LD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        req_c  = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) nxt = WB_MEM;
      end
      WB_MEM: begin
        rw_c   = 1'b1;
        wb_sel = 2'b01;
        ret_c  = 1'b1;
        nxt    = FETCH;
      end
      MEM_WR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) begin
          ret_c = 1'b1;
          nxt   = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b11;
        pc_src    = 1'b1;
        if (func3 == 3'b010 || func3 == 3'b011) begin
          nxt = TRAP;
        end else begin
          pcw_c = taken;
          ret_c = 1'b1;
          nxt   = FETCH;
        end
      end
      JAL: begin
        pcw_c  = 1'b1;
        pc_src = 1'b1;
        rw_c   = 1'b1;
        wb_sel = 2'b10;
        ret_c  = 1'b1;
        nxt    = FETCH;
      end
      TRAP: nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  // Enables are forced low while reset is held, without waiting for a clock.
  assign mem_req   = rst_n & req_c;
  assign mem_we    = rst_n & we_c;
  assign ir_write  = rst_n & irw_c;
  assign pc_write  = rst_n & pcw_c;
  assign reg_write = rst_n & rw_c;
  assign retire    = rst_n & ret_c;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control.
// Expected per-cycle output words are queued when stimulus is driven.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       alu_zero, alu_lsb, mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
  logic       alu_src_a, reg_write, retire, illegal;
  logic [1:0] alu_src_b, alu_op, wb_sel;

  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic       p_z, p_l;

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_SY = 7'b1110011;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                retire, illegal};

  function automatic logic [16:0] o(
    input logic mrq, mwe, iod, irw, pcw, pcs, asa,
    input logic [1:0] asb, aop,
    input logic rw, input logic [1:0] wb, input logic ret, ill);
    return {mrq, mwe, iod, irw, pcw, pcs, asa, asb, aop, rw, wb, ret, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [6:0] op, input logic [2:0] f3,
                    input logic z, input logic l);
    p_op = op; p_f3 = f3; p_z = z; p_l = l;
  endtask

  task automatic cyc(input string tag, input logic rdy,
                     input logic [16:0] e);
    @(posedge clk); #1;
    opcode = p_op; func3 = p_f3; alu_zero = p_z; alu_lsb = p_l;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chk(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
  endtask

  task automatic rst_pulse(input string tag);
    #2;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_en"},
        32'({ir_write, pc_write, reg_write, retire, mem_we}), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  logic [16:0] E_F1, E_F0, E_DEC, E_EXR, E_EXI, E_WBA, E_ADR;
  logic [16:0] E_MRD, E_WBM, E_MW0, E_MW1, E_BRT, E_BRN, E_BRX;
  logic [16:0] E_JAL, E_TRP;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    E_F1  = o(1,0,0,1,1,0,0,2'b01,2'b00,0,2'b00,0,0);
    E_F0  = o(1,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,0,0);
    E_DEC = o(0,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0);
    E_EXR = o(0,0,0,0,0,0,1,2'b00,2'b10,0,2'b00,0,0);
    E_EXI = o(0,0,0,0,0,0,1,2'b10,2'b01,0,2'b00,0,0);
    E_WBA = o(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b00,1,0);
    E_ADR = o(0,0,0,0,0,0,1,2'b10,2'b00,0,2'b00,0,0);
    E_MRD = o(1,0,1,0,0,0,0,2'b00,2'b00,0,2'b00,0,0);
    E_WBM = o(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b01,1,0);
    E_MW0 = o(1,1,1,0,0,0,0,2'b00,2'b00,0,2'b00,0,0);
    E_MW1 = o(1,1,1,0,0,0,0,2'b00,2'b00,0,2'b00,1,0);
    E_BRT = o(0,0,0,0,1,1,1,2'b00,2'b11,0,2'b00,1,0);
    E_BRN = o(0,0,0,0,0,1,1,2'b00,2'b11,0,2'b00,1,0);
    E_BRX = o(0,0,0,0,0,1,1,2'b00,2'b11,0,2'b00,0,0);
    E_JAL = o(0,0,0,0,1,1,0,2'b00,2'b00,1,2'b10,1,0);
    E_TRP = o(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,1);

    rst_n = 1'b0;
    mem_ready = 1'b1;
    ld(OP_R, 3'b000, 1'b0, 1'b0);
    opcode = p_op; func3 = p_f3; alu_zero = 1'b0; alu_lsb = 1'b0;
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_en",
        32'({ir_write, pc_write, reg_write, retire, mem_we}), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    cyc("first_fetch", 1'b0, E_F0);
    cyc("add_f", 1'b1, E_F1);
    cyc("add_d", 1'b1, E_DEC);
    cyc("add_ex", 1'b1, E_EXR);
    cyc("add_wb", 1'b1, E_WBA);

    ld(OP_LD, 3'b010, 1'b0, 1'b0);
    cyc("ld_f", 1'b1, E_F1);
    cyc("ld_d", 1'b1, E_DEC);
    cyc("ld_a", 1'b1, E_ADR);
    for (int i = 0; i < 3; i++) cyc("ld_wait", 1'b0, E_MRD);
    cyc("ld_rd", 1'b1, E_MRD);
    cyc("ld_wb", 1'b1, E_WBM);

    ld(OP_ST, 3'b010, 1'b0, 1'b0);
    cyc("st_fw", 1'b0, E_F0);
    cyc("st_f", 1'b1, E_F1);
    cyc("st_d", 1'b1, E_DEC);
    cyc("st_a", 1'b1, E_ADR);
    cyc("st_wr", 1'b1, E_MW1);

    ld(OP_I, 3'b000, 1'b0, 1'b0);
    cyc("addi_f", 1'b1, E_F1);
    cyc("addi_d", 1'b1, E_DEC);
    cyc("addi_ex", 1'b1, E_EXI);
    cyc("addi_wb", 1'b1, E_WBA);

    ld(OP_BR, 3'b001, 1'b0, 1'b0);
    cyc("bne_f", 1'b1, E_F1);
    cyc("bne_d", 1'b1, E_DEC);
    cyc("bne_t", 1'b1, E_BRT);
    ld(OP_BR, 3'b001, 1'b1, 1'b0);
    cyc("bne2_f", 1'b1, E_F1);
    cyc("bne2_d", 1'b1, E_DEC);
    cyc("bne_nt", 1'b1, E_BRN);
    ld(OP_BR, 3'b000, 1'b1, 1'b0);
    cyc("beq_f", 1'b1, E_F1);
    cyc("beq_d", 1'b1, E_DEC);
    cyc("beq_t", 1'b1, E_BRT);
    ld(OP_BR, 3'b111, 1'b0, 1'b1);
    cyc("bgeu_f", 1'b1, E_F1);
    cyc("bgeu_d", 1'b1, E_DEC);
    cyc("bgeu_nt", 1'b1, E_BRN);
    ld(OP_BR, 3'b111, 1'b0, 1'b0);
    cyc("bgeu2_f", 1'b1, E_F1);
    cyc("bgeu2_d", 1'b1, E_DEC);
    cyc("bgeu_t", 1'b1, E_BRT);
    ld(OP_BR, 3'b100, 1'b0, 1'b1);
    cyc("blt_f", 1'b1, E_F1);
    cyc("blt_d", 1'b1, E_DEC);
    cyc("blt_t", 1'b1, E_BRT);

    ld(OP_J, 3'b000, 1'b0, 1'b0);
    cyc("jal_f", 1'b1, E_F1);
    cyc("jal_d", 1'b1, E_DEC);
    cyc("jal_x", 1'b1, E_JAL);

    ld(OP_SY, 3'b000, 1'b0, 1'b0);
    cyc("sys_f", 1'b1, E_F1);
    cyc("sys_d", 1'b1, E_DEC);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 1'(i), E_TRP);
    rst_pulse("trap_rst");
    ld(OP_R, 3'b000, 1'b0, 1'b0);
    cyc("post_trap_f", 1'b0, E_F0);

    ld(OP_ST, 3'b010, 1'b0, 1'b0);
    cyc("stw_f", 1'b1, E_F1);
    cyc("stw_d", 1'b1, E_DEC);
    cyc("stw_a", 1'b1, E_ADR);
    cyc("stw_wait", 1'b0, E_MW0);
    cyc("stw_wait2", 1'b0, E_MW0);
    rst_pulse("stw_rst");
    ld(OP_R, 3'b000, 1'b0, 1'b0);
    cyc("re_f", 1'b1, E_F1);
    cyc("re_d", 1'b1, E_DEC);
    cyc("re_ex", 1'b1, E_EXR);
    cyc("re_wb", 1'b1, E_WBA);

    ld(OP_BR, 3'b010, 1'b0, 1'b0);
    cyc("bx_f", 1'b1, E_F1);
    cyc("bx_d", 1'b1, E_DEC);
    cyc("bx_br", 1'b1, E_BRX);
    cyc("bx_trap", 1'b1, E_TRP);
    rst_pulse("bx_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  7  instruction[6:0] from instruction register.
REQ-005 func3  in  3  instruction[14:12].
REQ-006 alu_zero  in  1  ALU result == 0.
REQ-007 alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome).
REQ-008 mem_ready  in  1  memory completes current request this cycle.
REQ-009 mem_req  out  1  memory request, held until mem_ready.
REQ-010 mem_we  out  1  request is a write; valid only with mem_req.
REQ-011 i_or_d  out  1  0 = memory address from PC, 1 = from ALU result register.
REQ-012 ir_write  out  1  load instruction register.
REQ-013 pc_write  out  1  load PC from next-PC mux.
REQ-014 pc_src  out  1  0 = ALU output (PC+4), 1 = branch/jump target register.
REQ-015 alu_src_a  out  1  0 = PC, 1 = rs1.
REQ-016 alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
REQ-017 alu_op  out  2  00 = ADD, 01 = I-type, 10 = R-type, 11 = branch compare (to ALU control decoder).
REQ-018 reg_write  out  1  register-file write enable.
REQ-019 wb_sel  out  2  00 = ALU result, 01 = memory data, 10 = PC+4.
REQ-020 retire  out  1  one-cycle pulse per completed instruction.
REQ-021 illegal  out  1  unsupported opcode or branch func3 trapped; sticky.

Function
REQ-022 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP; state register only sequential element besides illegal.
REQ-023 FETCH: mem_req=1, mem_we=0, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; on mem_ready assert ir_write, pc_write, pc_src=0 and go DECODE; else stay.
REQ-024 DECODE (one cycle): alu_src_a=0, alu_src_b=10, alu_op=00 (target = PC+imm latched externally); next by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JAL, other->TRAP.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=01 -> WB_ALU.
REQ-026 WB_ALU: reg_write=1, wb_sel=00, retire=1 -> FETCH.
REQ-027 ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; opcode 0000011->MEM_RD, else MEM_WR.
REQ-028 MEM_RD: mem_req=1, mem_we=0, i_or_d=1; on mem_ready -> WB_MEM. WB_MEM: reg_write=1, wb_sel=01, retire=1 -> FETCH.
REQ-029 MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready retire=1 -> FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=11; taken = func3 000: alu_zero; 001: !alu_zero; 100/110: alu_lsb; 101/111: !alu_lsb; pc_write=taken, pc_src=1, retire=1 -> FETCH; func3 010/011 -> TRAP, no retire, no pc_write.
REQ-031 JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=10, retire=1 -> FETCH.
REQ-032 TRAP: illegal=1, all enables 0; remains until reset.
REQ-033 Outputs SHALL be combinational from state (plus opcode/func3/flags where stated); unlisted outputs 0 in each state.
REQ-034 mem_req SHALL remain asserted with stable mem_we/i_or_d every cycle until mem_ready; mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-035 Latency (mem_ready immediate): R/I 4 cycles, load 5, store 4, branch 3, JAL 3; each wait cycle adds 1.

Reset
REQ-036 rst_n low SHALL immediately force state=FETCH, illegal=0, regardless of clock, including mid-memory-wait.
REQ-037 During reset all enables SHALL be 0 (mem_req, ir_write, pc_write, reg_write, retire).
REQ-038 First rising edge after rst_n release SHALL be a FETCH cycle with mem_req=1.

Verification
REQ-039 ADD (0110011, func3 000), mem_ready tied 1 -> alu_op 10 in cycle 3, reg_write+retire in cycle 4, back in FETCH cycle 5.
REQ-040 Load with mem_ready low 3 cycles in MEM_RD -> mem_req=1, i_or_d=1 held 4 cycles; WB_MEM wb_sel=01 one cycle; total 8 cycles.
REQ-041 BNE, alu_zero=0 -> pc_write=1, pc_src=1 in BRANCH; repeat with alu_zero=1 -> pc_write=0, retire=1.
REQ-042 BGEU (func3 111), alu_lsb=1 -> not taken; alu_lsb=0 -> taken.
REQ-043 Opcode 1110011 -> TRAP, illegal=1 held 20 cycles, no mem_req; rst_n pulse -> illegal=0, FETCH.
REQ-044 rst_n asserted mid-MEM_WR wait -> mem_req drops same cycle without clock edge; restart in FETCH.
